rf_multiport: RTL and testbench

Parametrised multi-port register file for the CPU datapath, the next generation of the two-read/one-write architectural register file. It adds configurable data width, depth, read and write port counts, per-byte write enables, and optional write-to-read bypass. It also has a per-register busy scoreboard for pipeline hazard detection and a registered-state debug tap. It sits between decode (reads and busy set) and writeback (writes and busy clear).

---
 rtl/rf_multiport.sv | 96 +++++++++
 tb/tb_rf_multiport.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/rf_multiport.sv
// Multi-port register file with per-byte write enables, optional write-to-read
// bypass, a per-register busy scoreboard for hazard detection and a debug tap.
module rf_multiport #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_WR-1:0]        we,
    input  logic [NUM_WR*ADDR_W-1:0] wR,
    input  logic [NUM_WR*DATA_W-1:0] wD,
    input  logic [NUM_WR*DATA_W/8-1:0] wBE,
    input  logic [NUM_RD*ADDR_W-1:0] rR,
    output logic [NUM_RD*DATA_W-1:0] rD,
    output logic [NUM_RD-1:0]        rbusy,
    input  logic                     busy_set,
    input  logic [ADDR_W-1:0]        busy_idx,
    input  logic [ADDR_W-1:0]        dbg_sel,
    output logic [DATA_W-1:0]        dbg_data
);
    localparam int DEPTH   = 1 << ADDR_W;
    localparam int BE_W    = DATA_W / 8;
    localparam bit ZERO_EN = (ZERO_REG != 0);
    localparam bit BYP_EN  = (BYPASS != 0);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  busy;

    // Ports are applied in ascending order so the highest port wins a shared byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
        end else begin
            for (int p = 0; p < NUM_WR; p++) begin
                if (we[p] && !(ZERO_EN && wR[p*ADDR_W +: ADDR_W] == '0)) begin
                    for (int b = 0; b < BE_W; b++) begin
                        if (wBE[p*BE_W + b])
                            mem[wR[p*ADDR_W +: ADDR_W]][b*8 +: 8] <= wD[p*DATA_W + b*8 +: 8];
                    end
                end
            end
        end
    end

    // Clears come first so a same-cycle set on the same index overrides them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            for (int p = 0; p < NUM_WR; p++) begin
                if (we[p]) busy[wR[p*ADDR_W +: ADDR_W]] <= 1'b0;
            end
            if (busy_set && !(ZERO_EN && busy_idx == '0))
                busy[busy_idx] <= 1'b1;
        end
    end

    always_comb begin
        logic [ADDR_W-1:0] idx;
        logic [DATA_W-1:0] val;
        logic              hit;
        rD    = '0;
        rbusy = '0;
        idx   = '0;
        val   = '0;
        hit   = 1'b0;
        for (int i = 0; i < NUM_RD; i++) begin
            idx = rR[i*ADDR_W +: ADDR_W];
            val = mem[idx];
            hit = 1'b0;
            if (BYP_EN) begin
                for (int p = 0; p < NUM_WR; p++) begin
                    if (we[p] && wR[p*ADDR_W +: ADDR_W] == idx) begin
                        hit = 1'b1;
                        for (int b = 0; b < BE_W; b++) begin
                            if (wBE[p*BE_W + b])
                                val[b*8 +: 8] = wD[p*DATA_W + b*8 +: 8];
                        end
                    end
                end
            end
            // Reset gating keeps bypassed write data off the read bus while held.
            if (rst_n && !(ZERO_EN && idx == '0)) begin
                rD[i*DATA_W +: DATA_W] = val;
                rbusy[i]               = busy[idx] & ~hit;
            end
        end
    end

    assign dbg_data = (ZERO_EN && dbg_sel == '0) ? '0 : mem[dbg_sel];

endmodule

// File: tb/tb_rf_multiport.sv
// Directed bench for rf_multiport: a bypassing instance and a non-bypassing
// instance share all inputs; expected values flow through a queue scoreboard.
module tb_rf_multiport;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  we;
    logic [9:0]  wR;
    logic [63:0] wD;
    logic [7:0]  wBE;
    logic [9:0]  rR;
    logic [63:0] rD, rD_nb;
    logic [1:0]  rbusy, rbusy_nb;
    logic        busy_set;
    logic [4:0]  busy_idx;
    logic [4:0]  dbg_sel;
    logic [31:0] dbg_data, dbg_nb;

    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [31:0] exp_q[$];

    rf_multiport #(.BYPASS(1)) dut (
        .clk(clk), .rst_n(rst_n), .we(we), .wR(wR), .wD(wD), .wBE(wBE),
        .rR(rR), .rD(rD), .rbusy(rbusy), .busy_set(busy_set),
        .busy_idx(busy_idx), .dbg_sel(dbg_sel), .dbg_data(dbg_data)
    );

    rf_multiport #(.BYPASS(0)) dut_nb (
        .clk(clk), .rst_n(rst_n), .we(we), .wR(wR), .wD(wD), .wBE(wBE),
        .rR(rR), .rD(rD_nb), .rbusy(rbusy_nb), .busy_set(busy_set),
        .busy_idx(busy_idx), .dbg_sel(dbg_sel), .dbg_data(dbg_nb)
    );

    always #5 clk = ~clk;

    initial begin
        #50000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic expect_val(input logic [31:0] v);
        exp_q.push_back(v);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs);
        logic [31:0] e;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $error("FAIL %s: observed %h, no expected value queued", tag, obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e) else begin
                n_fail++;
                $error("FAIL %s: observed %h expected %h", tag, obs, e);
            end
        end
    endtask

    task automatic set_wr(input int p, input logic [4:0] idx, input logic [31:0] d,
                          input logic [3:0] be);
        we[p]           = 1'b1;
        wR[p*5 +: 5]    = idx;
        wD[p*32 +: 32]  = d;
        wBE[p*4 +: 4]   = be;
    endtask

    task automatic idle();
        we       = '0;
        wBE      = '0;
        busy_set = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [4:0] j;
        rst_n = 1'b0; we = '0; wR = '0; wD = '0; wBE = '0; rR = '0;
        busy_set = 1'b0; busy_idx = '0; dbg_sel = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        rR[4:0] = 5'd3; dbg_sel = 5'd3;
        #1;
        expect_val(32'h0); chk("rst_rd0", rD[31:0]);
        expect_val(32'h0); chk("rst_dbg", dbg_data);
        expect_val(32'h0); chk("rst_rbusy", {30'b0, rbusy});
        rst_n = 1'b1;
        tick();

        // Full write to reg 3: bypassed same cycle, debug after the edge
        set_wr(0, 5'd3, 32'hDEADBEEF, 4'hF);
        #1;
        expect_val(32'hDEADBEEF); chk("byp_rd0_same", rD[31:0]);
        expect_val(32'h0);        chk("dbg_before", dbg_data);
        expect_val(32'h0);        chk("nb_rd0_same", rD_nb[31:0]);
        tick();
        idle();
        #1;
        expect_val(32'hDEADBEEF); chk("dbg_after", dbg_data);
        expect_val(32'hDEADBEEF); chk("nb_rd0_after", rD_nb[31:0]);

        // Dual write to reg 5 with port 1 taking the low half
        set_wr(0, 5'd5, 32'h11223344, 4'hF);
        set_wr(1, 5'd5, 32'hAABBCCDD, 4'h3);
        rR[9:5] = 5'd5;
        #1;
        expect_val(32'h1122CCDD); chk("dual_byp", rD[63:32]);
        tick();
        idle();
        dbg_sel = 5'd5;
        #1;
        expect_val(32'h1122CCDD); chk("dual_dbg", dbg_data);
        expect_val(32'h1122CCDD); chk("dual_nb", rD_nb[63:32]);

        // Register 0 stays zero and never busy
        set_wr(0, 5'd0, 32'hFFFFFFFF, 4'hF);
        busy_set = 1'b1; busy_idx = 5'd0;
        rR[4:0] = 5'd0; dbg_sel = 5'd0;
        #1;
        expect_val(32'h0); chk("z_byp_same", rD[31:0]);
        tick();
        idle();
        #1;
        expect_val(32'h0); chk("z_rd", rD[31:0]);
        expect_val(32'h0); chk("z_rbusy", {31'b0, rbusy[0]});
        expect_val(32'h0); chk("z_dbg", dbg_data);
        tick();
        expect_val(32'h0); chk("z_rd_later", rD_nb[31:0]);
        expect_val(32'h0); chk("z_rbusy_nb", {31'b0, rbusy_nb[0]});

        // Scoreboard on index 7
        busy_set = 1'b1; busy_idx = 5'd7; rR[4:0] = 5'd7;
        #1;
        expect_val(32'h0); chk("sb_set_not_fwd", {31'b0, rbusy[0]});
        tick();
        idle();
        #1;
        expect_val(32'h1); chk("sb_busy", {31'b0, rbusy[0]});
        expect_val(32'h1); chk("sb_busy_nb", {31'b0, rbusy_nb[0]});
        set_wr(0, 5'd7, 32'hCAFEF00D, 4'h0);
        #1;
        expect_val(32'h0); chk("sb_clr_byp", {31'b0, rbusy[0]});
        expect_val(32'h1); chk("sb_clr_nb_same", {31'b0, rbusy_nb[0]});
        tick();
        idle();
        #1;
        expect_val(32'h0); chk("sb_cleared", {31'b0, rbusy[0]});
        expect_val(32'h0); chk("sb_cleared_nb", {31'b0, rbusy_nb[0]});
        expect_val(32'h0); chk("sb_be0_nodata", rD[31:0]);
        set_wr(0, 5'd7, 32'h0, 4'h0);
        busy_set = 1'b1; busy_idx = 5'd7;
        #1;
        expect_val(32'h0); chk("sb_setclr_same", {31'b0, rbusy[0]});
        tick();
        idle();
        #1;
        expect_val(32'h1); chk("sb_set_wins", {31'b0, rbusy[0]});
        expect_val(32'h1); chk("sb_set_wins_nb", {31'b0, rbusy_nb[0]});

        // Non-bypassed read of a write in flight
        set_wr(0, 5'd2, 32'h55, 4'hF);
        rR[9:5] = 5'd2;
        #1;
        expect_val(32'h0);  chk("nb_old", rD_nb[63:32]);
        expect_val(32'h55); chk("byp_new", rD[63:32]);
        tick();
        idle();
        #1;
        expect_val(32'h55); chk("nb_new", rD_nb[63:32]);

        // Fill every register with its own index
        for (int k = 0; k < 32; k += 2) begin
            set_wr(0, 5'(k), 32'(k), 4'hF);
            set_wr(1, 5'(k + 1), 32'(k + 1), 4'hF);
            tick();
        end
        idle();
        repeat (6) begin
            j = 5'($urandom_range(0, 31));
            rR[4:0] = j;
            #1;
            expect_val(32'(j)); chk("fill_rd", rD[31:0]);
        end
        rR[4:0] = 5'd20; rR[9:5] = 5'd31; dbg_sel = 5'd17;
        #1;
        expect_val(32'd20); chk("pre_rst_rd0", rD[31:0]);
        expect_val(32'd17); chk("pre_rst_dbg", dbg_data);

        // Asynchronous reset mid-cycle clears immediately
        rst_n = 1'b0;
        #1;
        expect_val(32'h0); chk("arst_rd0", rD[31:0]);
        expect_val(32'h0); chk("arst_rd1", rD[63:32]);
        expect_val(32'h0); chk("arst_dbg", dbg_data);
        expect_val(32'h0); chk("arst_nb_rd1", rD_nb[63:32]);

        // Write and set held across the release edge are lost
        set_wr(0, 5'd9, 32'h00001234, 4'hF);
        busy_set = 1'b1; busy_idx = 5'd9;
        rR[4:0] = 5'd9; dbg_sel = 5'd9;
        #1;
        expect_val(32'h0); chk("rst_held_byp", rD[31:0]);
        @(posedge clk);
        rst_n <= 1'b1;
        #1;
        idle();
        #1;
        expect_val(32'h0); chk("rel_rd", rD[31:0]);
        expect_val(32'h0); chk("rel_dbg", dbg_data);
        expect_val(32'h0); chk("rel_rbusy", {31'b0, rbusy[0]});
        set_wr(0, 5'd9, 32'h00001234, 4'hF);
        tick();
        idle();
        #1;
        expect_val(32'h00001234); chk("post_rel_wr", dbg_data);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
